mul_arbiter: RTL

- Shares one pipelined 32x32->64 unsigned multiplier (multiplier_pipelined, fixed latency) between N requesters.
- Round-robin arbitration on a valid/ready request channel; at most one issue per cycle into the multiplier.
- Carries the requester ID through a tag pipeline aligned to the multiplier latency and returns each product to its originator.
- Sits between client blocks and the multiplier instance. The multiplier is instantiated beside this block, not inside it.

---
 rtl/mul_arb_pkg.sv | 15 +
 rtl/mul_arbiter_rr.sv | 61 ++++++
 rtl/multiplier_pipelined.sv | 30 +++
 rtl/mul_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared widths and the {valid, id} tag that travels beside each multiply.
// ID width is sized for the largest supported requester count (8).
package mul_arb_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 2 * OP_W;
  localparam int N_MAX  = 8;
  localparam int ID_W   = $clog2(N_MAX);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_arbiter_rr.sv
// Round-robin arbiter: search starts at r_ptr and wraps; pointer moves to
// one past the winner whenever a grant is issued.
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_cand;
  logic [ID_W:0]   w_inc;
  logic [ID_W-1:0] w_next;
  logic [ID_W-1:0] w_idx;
  logic [N-1:0]    w_grant;
  logic            w_found;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the search loop can leave a value held (no latch).
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(N)) w_cand = w_cand - (ID_W+1)'(N);
      for (int j = 0; j < N; j++) begin
        if (!w_found && (w_cand == (ID_W+1)'(j)) && i_req[j]) begin
          w_found    = 1'b1;
          w_idx      = ID_W'(j);
          w_grant[j] = 1'b1;
        end
      end
    end
  end

  assign w_inc  = {1'b0, w_idx} + (ID_W+1)'(1);
  assign w_next = (w_inc == (ID_W+1)'(N)) ? '0 : w_inc[ID_W-1:0];

  // NOTE: state updates use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next;
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = w_found;

endmodule

// File: rtl/multiplier_pipelined.sv
// Unsigned W x W -> 2W multiplier: operand register, then LATENCY product stages.
// Product for operands sampled at edge S is valid after edge S+LATENCY.
module multiplier_pipelined #(
  parameter int W       = 32,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_p [LATENCY];

  // NOTE: pure datapath with no reset; validity is tracked by the caller's tag
  // pipeline, so clearing these flops would only cost routing.
  always_ff @(posedge clk) begin
    r_a    <= i_a;
    r_b    <= i_b;
    r_p[0] <= (2*W)'(r_a) * (2*W)'(r_b);
    for (int s = 1; s < LATENCY; s++) begin
      r_p[s] <= r_p[s-1];
    end
  end

  assign o_p = r_p[LATENCY-1];

endmodule

// File: rtl/mul_arbiter.sv
// Shares one pipelined multiplier among N requesters; each product returns
// to its originator as a one-cycle pulse LATENCY+2 cycles after acceptance.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int LATENCY = 2,
  parameter int W       = OP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_r,
  output logic [N-1:0]   resp_valid,
  output logic [2*W-1:0] resp_r,
  output logic           busy,
  output logic [31:0]    issue_count
);

  // Stage 0 aligns with mul_a; the last stage lines up with mul_r being valid.
  localparam int DEPTH = LATENCY + 2;

  logic [N-1:0]    w_grant;
  logic [ID_W-1:0] w_idx;
  logic            w_xfer;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [N-1:0]    w_resp_oh;
  logic            w_busy;

  logic [W-1:0]    r_mul_a;
  logic [W-1:0]    r_mul_b;
  tag_t            r_tag [DEPTH];
  logic [N-1:0]    r_resp_valid;
  logic [2*W-1:0]  r_resp_r;
  logic [31:0]     r_issue_count;

  rr_arbiter #(.N(N)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_xfer)
  );

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int j = 0; j < N; j++) begin
      if (w_grant[j]) begin
        w_a = req_a[j*W +: W];
        w_b = req_b[j*W +: W];
      end
    end
  end

  always_comb begin
    w_resp_oh = '0;
    for (int j = 0; j < N; j++) begin
      w_resp_oh[j] = r_tag[DEPTH-1].valid && (r_tag[DEPTH-1].id == ID_W'(j));
    end
    w_busy = |r_resp_valid;
    for (int s = 0; s < DEPTH; s++) begin
      w_busy = w_busy | r_tag[s].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_resp_valid  <= '0;
      r_resp_r      <= '0;
      r_issue_count <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_xfer, id: w_idx};
      for (int s = 1; s < DEPTH; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      if (w_xfer) begin
        r_mul_a       <= w_a;
        r_mul_b       <= w_b;
        r_issue_count <= r_issue_count + 32'd1;
      end
      r_resp_valid <= w_resp_oh;
      if (r_tag[DEPTH-1].valid) r_resp_r <= mul_r;
    end
  end

  assign req_ready   = w_grant;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign resp_valid  = r_resp_valid;
  assign resp_r      = r_resp_r;
  assign busy        = w_busy;
  assign issue_count = r_issue_count;

endmodule
